// File: rtl/fwd_pkg.sv
// Shared types and width helpers for the forwarding scoreboard.
// Slot record, register-file select code, derived-width functions.
package fwd_pkg;

  localparam int MAX_REG_W = 8;
  localparam int FWD_RF    = 0;

  typedef struct packed {
    logic                 valid;
    logic [MAX_REG_W-1:0] wsel;
    logic                 is_load;
  } slot_t;

  function automatic int reg_w(input int nregs);
    return (nregs > 2) ? $clog2(nregs) : 1;
  endfunction

  function automatic int sel_w(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Single-operand priority match against all in-flight slots.
// Youngest valid producer wins; reports not-ready as a stall.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int DATA_W     = 32,
  parameter int SEL_W      = 2,
  parameter int ALU_READY  = 0,
  parameter int LOAD_READY = 1
) (
  input  slot_t [STAGES-1:0]        i_slots,
  input  logic  [MAX_REG_W-1:0]     i_src,
  input  logic  [STAGES*DATA_W-1:0] i_data,
  output logic  [SEL_W-1:0]         o_sel,
  output logic  [DATA_W-1:0]        o_data,
  output logic                      o_stall
);

  // scan oldest to youngest so a younger hit overrides an older one
  always_comb begin
    o_sel   = SEL_W'(FWD_RF);
    o_data  = '0;
    o_stall = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (i_slots[k].valid && i_slots[k].wsel == i_src &&
          i_src != '0) begin
        o_sel   = SEL_W'(k + 1);
        o_data  = i_data[k*DATA_W +: DATA_W];
        o_stall = i_slots[k].is_load ? (k < LOAD_READY)
                                     : (k < ALU_READY);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Parametrised forwarding/hazard scoreboard over STAGES in-flight slots.
// Optional counters: define FWD_SCOREBOARD_PERF_EN.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter  int NREGS      = 32,
  parameter  int DATA_W     = 32,
  parameter  int STAGES     = 3,
  parameter  int NSRC       = 2,
  parameter  int ALU_READY  = 0,
  parameter  int LOAD_READY = 1,
  localparam int REG_W      = reg_w(NREGS),
  localparam int SEL_W      = sel_w(STAGES)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     advance,
  input  logic                     issue_valid,
  input  logic                     issue_regwrite,
  input  logic                     issue_load,
  input  logic [REG_W-1:0]         issue_wsel,
  input  logic [NSRC*REG_W-1:0]    src_sel,
  input  logic [STAGES*DATA_W-1:0] stage_data,
  input  logic [STAGES-1:0]        flush,
  output logic [NSRC*SEL_W-1:0]    fwd_sel,
  output logic [NSRC*DATA_W-1:0]   fwd_data,
  output logic                     stall,
  output logic [STAGES-1:0]        slot_valid
`ifdef FWD_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]              perf_stalls,
  output logic [31:0]              perf_fwds
`endif
);

  generate
    if (LOAD_READY >= STAGES || LOAD_READY < ALU_READY ||
        REG_W > MAX_REG_W) begin : g_bad_cfg
      $error("fwd_scoreboard: illegal parameter set");
    end
  endgenerate

  slot_t [STAGES-1:0] r_slots;
  slot_t [STAGES-1:0] w_kept;
  slot_t              w_new;
  logic  [NSRC-1:0]   w_op_stall;
  logic               w_stall;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    fwd_match #(
      .STAGES     (STAGES),
      .DATA_W     (DATA_W),
      .SEL_W      (SEL_W),
      .ALU_READY  (ALU_READY),
      .LOAD_READY (LOAD_READY)
    ) u_match (
      .i_slots (r_slots),
      .i_src   (MAX_REG_W'(src_sel[s*REG_W +: REG_W])),
      .i_data  (stage_data),
      .o_sel   (fwd_sel[s*SEL_W +: SEL_W]),
      .o_data  (fwd_data[s*DATA_W +: DATA_W]),
      .o_stall (w_op_stall[s])
    );
  end

  assign w_stall = |w_op_stall;
  assign stall   = w_stall;

  // kill masked slots, build the entry for the decoding instruction
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_kept[k] = r_slots[k];
      if (flush[k]) w_kept[k].valid = 1'b0;
    end
    w_new.valid   = issue_valid & issue_regwrite & ~w_stall;
    w_new.wsel    = MAX_REG_W'(issue_wsel);
    w_new.is_load = issue_load;
  end

  // shift on advance, otherwise only apply the flush in place
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_slots <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (!advance)    r_slots[k] <= w_kept[k];
        else if (k == 0) r_slots[k] <= w_new;
        else             r_slots[k] <= w_kept[(k == 0) ? 0 : k - 1];
      end
    end
  end

  // debug occupancy view
  always_comb begin
    for (int k = 0; k < STAGES; k++) slot_valid[k] = r_slots[k].valid;
  end

`ifdef FWD_SCOREBOARD_PERF_EN
  localparam int NFW = $clog2(NSRC + 1);

  logic [31:0]    r_perf_stalls;
  logic [31:0]    r_perf_fwds;
  logic [NFW-1:0] w_nfwd;
  logic [32:0]    w_fwd_sum;

  // operands actually served by a bypass this cycle
  always_comb begin
    w_nfwd = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (fwd_sel[s*SEL_W +: SEL_W] != '0 && !w_op_stall[s])
        w_nfwd = w_nfwd + NFW'(1);
    end
    w_fwd_sum = {1'b0, r_perf_fwds} + 33'(w_nfwd);
  end

  // saturating event counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_perf_stalls <= '0;
      r_perf_fwds   <= '0;
    end else begin
      if (advance && w_stall && r_perf_stalls != '1)
        r_perf_stalls <= r_perf_stalls + 32'd1;
      r_perf_fwds <= w_fwd_sum[32] ? '1 : w_fwd_sum[31:0];
    end
  end

  assign perf_stalls = r_perf_stalls;
  assign perf_fwds   = r_perf_fwds;
`endif

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the fixed two-stage forwarding/hazard logic of the five-stage MIPS pipeline.
- Tracks every in-flight register write across STAGES pipeline slots.
- For each of NSRC source operands it selects the youngest producing slot, or the register file.
- Raises a load-use stall when the producer's data is not yet available; bubbles and flushes are handled internally.

Parameters:
- NREGS, 32, architectural register count; REG_W = $clog2(NREGS).
- DATA_W, 32, datapath word width.
- STAGES, 3, in-flight slots tracked after issue (EX/MEM, MEM/WB, WB-latch).
- NSRC, 2, source operands checked per issue.
- ALU_READY, 0, first slot index where a non-load result is valid.
- LOAD_READY, 1, first slot index where load data is valid; must be >= ALU_READY and < STAGES.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- advance  in  1  pipeline enable (ihit/dhit qualified); slots shift only when high.
- issue_valid  in  1  instruction in decode presents a write.
- issue_regwrite  in  1  instruction writes a register.
- issue_load  in  1  instruction is a load.
- issue_wsel  in  REG_W  destination register.
- src_sel  in  NSRC*REG_W  source register numbers, operand 0 in the LSBs.
- stage_data  in  STAGES*DATA_W  result value held in each slot, slot 0 in the LSBs.
- flush  in  STAGES  per-slot kill mask.
- fwd_sel  out  NSRC*SEL_W  per operand: 0 = register file, k+1 = slot k; SEL_W = $clog2(STAGES+1).
- fwd_data  out  NSRC*DATA_W  forwarded value; register-file bypass gives 0.
- stall  out  1  hold fetch/decode and insert a bubble.
- slot_valid  out  STAGES  debug view of slot occupancy.

Behaviour:
- Slot state: valid, wsel, is_load. Slot k holds the instruction issued k+1 accepted advances ago.
- Reset (async, RST=1): all slots invalid. Outputs then read stall=0, fwd_sel=0, fwd_data=0, slot_valid=0.
- Match rule for slot k against source s:
  - slot valid;
  - wsel == src_sel[s];
  - src_sel[s] != 0 (register 0 never matches).
- Youngest (lowest k) match wins.
- Ready rule for the winning slot: k >= (is_load ? LOAD_READY : ALU_READY).
  - Ready: fwd_sel = k+1, fwd_data = stage_data[k].
  - Not ready: operand stalls, and its fwd_sel/fwd_data still show the winning slot.
  - No match: fwd_sel = 0, fwd_data = 0.
- stall = OR of per-operand stalls. fwd_sel, fwd_data and stall are combinational from slot state and inputs, so there is zero-cycle latency.
- On a clock edge with advance=1:
  - Slot k+1 takes slot k.
  - Slot STAGES-1 retires. The register file writes before it reads, so retired results need no tracking.
  - Slot 0 loads {issue_valid & issue_regwrite & !stall, issue_wsel, issue_load}. During a stall, slot 0 receives a bubble (valid=0).
- advance=0: all slots hold and combinational outputs keep evaluating.
- flush together with advance: the mask clears pre-shift slots, then the shift occurs. A flushed slot therefore moves as a bubble.
- flush without advance: the masked slots clear in place.
- A flush on the cycle of a stall still inserts a bubble at slot 0.
- Duplicate wsel in several slots: the youngest wins.
- STAGES=1 is legal. LOAD_READY >= STAGES is a static assertion failure.

Optional Feature:
- Macro: FWD_SCOREBOARD_PERF_EN.
- When defined, adds the outputs perf_stalls[31:0] and perf_fwds[31:0]:
  - perf_stalls increments on each advance cycle with stall=1.
  - perf_fwds increments per cycle by the number of operands with fwd_sel != 0 and not stalling.
  - Both counters saturate at 32'hFFFF_FFFF and clear on RST.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package fwd_pkg holds:
  - the slot_t struct {valid, wsel, is_load};
  - the fwd_sel encoding constant FWD_RF = 0;
  - widths derived through functions of the parameters.
- One natural sub-module, fwd_match: a single-operand priority match plus ready check. It is instantiated NSRC times in a generate loop.

Test Plan:
- Back-to-back ALU: issue wsel=5 (ALU), advance; next src_sel[0]=5 with stage_data[0]=32'h1234 -> fwd_sel[0]=1, fwd_data[0]=32'h1234, stall=0.
- Load-use: issue lw wsel=8 then src_sel[1]=8 -> stall=1 one cycle. Slot 0 gets a bubble; next cycle fwd_sel[1]=2, fwd_data = stage_data[1].
- Priority: slots 0 and 1 both wsel=3 (ALU), src_sel[0]=3 -> fwd_sel[0]=1; register 0 sources -> fwd_sel=0 even with wsel=0 in flight.
- Hold: advance=0 for 4 cycles after issuing wsel=9 -> slot_valid unchanged at 3'b001, with outputs stable.
- Flush plus advance: slots 3'b011, flush=3'b001, advance=1 -> slot_valid=3'b100 (new issue stalled/none); src matching the old slot 0 -> fwd_sel=0.
- Async reset mid-stall: RST pulse between edges -> stall=0 and slot_valid=0 immediately. With FWD_SCOREBOARD_PERF_EN, both counters read 0.
